grid_display_scan: RTL and testbench
====================================

# grid_display_scan

Row-multiplexed display driver sitting directly downstream of the Game-of-Life datapath. It consumes the 64-bit generation vector `grid` and drives an 8x8 LED matrix one row at a time. Each new generation is latched into a shadow register only at a frame boundary, so a frame never mixes two generations. It also reports a generation count and the live-cell population of the displayed frame.

## Interface
Parameters:
- `DWELL`, default 1000: clock cycles each row is lit; legal range 1..65535.
- `BLANK`, default 16: cycles of all-rows-off after each row (ghosting guard); 0 = no blanking.

Ports:
- `clka`, input, 1: single clock; all logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `grid`, input, 64: current generation; cell `8*r+c` is row r, column c.
- `grid_valid`, input, 1: one-cycle pulse when `grid` holds a new generation.
- `enable`, input, 1: scan enable.
- `row_sel`, output, 8: one-hot row drive, active-high; bit r lights row r.
- `col_data`, output, 8: column data for the lit row; bit c = shadow[8*r+c].
- `frame_done`, output, 1: one-cycle pulse after the last row of a frame.
- `gen_count`, output, 16: number of generations latched since reset; wraps 0xFFFF→0.
- `alive_count`, output, 7: population of the shadow register, 0..64.

## Operation
- State register `st`: IDLE, LOAD, SCAN, BLNK. Row counter `row` is 3 bits; dwell counter is 16 bits.
- `pending` flag is set by `grid_valid` and cleared in LOAD.
- IDLE: `row_sel=0`, `col_data=0`. If `enable`=1, go to LOAD.
- LOAD (exactly 1 cycle):
  - If `pending` or `grid_valid`: shadow ← `grid`, `gen_count` += 1, `alive_count` ← popcount(`grid`), and `pending` cleared.
  - Otherwise the shadow register is held.
  - Set `row`=0, then go to SCAN.
- SCAN (DWELL cycles): `row_sel` = 1<<`row`, `col_data` = shadow[8*row +: 8].
  - After the DWELL-th cycle, go to BLNK; if BLANK=0, go straight to the next row instead.
- BLNK (BLANK cycles): `row_sel=0`, `col_data=0`.
  - Then, if `row`<7: `row`+=1 and return to SCAN.
  - If `row`=7: pulse `frame_done` and go to LOAD.
- `grid_valid` is never lost: a pulse at any time other than LOAD sets `pending`. Several pulses within one frame collapse into one capture of `grid` as it stands at LOAD, and `gen_count` increments once.
- `grid_valid` in the LOAD cycle itself: that cycle's `grid` is captured and `pending` ends at 0.
- `enable` falling in any state: next state is IDLE, outputs are 0 from the next cycle, and `row` is reset.
  - Shadow, `gen_count`, `alive_count` and `pending` are retained.
  - Re-enabling restarts from LOAD at row 0.
- Popcount is combinational over the 64-bit `grid` and registered in LOAD only.

## Timing
- Reset (asynchronous, `rst_n`=0): `st`=IDLE, shadow=0, `pending`=0, `row_sel`=0, `col_data`=0, `frame_done`=0, `gen_count`=0, `alive_count`=0.
- All outputs are registered. `row_sel`/`col_data` for row r appear the cycle after the state register enters SCAN for that row.
- Frame length: 1 + 8*(DWELL+BLANK) cycles, LOAD to LOAD.
- `frame_done` is asserted in the LOAD cycle that follows row 7's blank (or row 7's last SCAN cycle when BLANK=0).
- Latency from `grid_valid` to new data on `col_data`: at most 1 frame + 2 cycles.
- `rst_n` asserted mid-frame: outputs go to 0 immediately (asynchronously). After release, the block waits in IDLE until `enable` is seen.
- `row_sel` is never multi-hot and never lit outside SCAN.

## Test plan
- DWELL=4, BLANK=2, `grid`=0x8040201008040201, pulse `grid_valid`, `enable`=1:
  - frame length is 49 cycles;
  - row r shows `col_data`=1<<r for 4 cycles, followed by 2 zero cycles;
  - `alive_count`=8, `gen_count`=1.
- Tear-free update: mid-frame (row 3), change `grid` to all-ones and pulse `grid_valid` → rows 4–7 of the current frame still show the old data. The next frame shows 0xFF on every row; `alive_count`=64, `gen_count`=2.
- Three `grid_valid` pulses in one frame with `grid` = 0x1, 0x3, 0x7 → `gen_count` +1 only, `alive_count`=3, row 0 `col_data`=0x07.
- `grid_valid` coincident with LOAD (`grid`=0xFF) → captured that cycle, `pending`=0, and no extra capture at the next LOAD.
- `enable` dropped during row 5 → `row_sel`=0 next cycle. Re-enable → LOAD then row 0, with `gen_count` unchanged.
- `rst_n` pulsed low during SCAN → all outputs 0 at once, `gen_count`=0; with BLANK=0 and DWELL=1 after re-run, frame length is 9 cycles.

Source files
------------

// File: rtl/grid_display_scan.sv
// Row-multiplexed 8x8 LED scan driver for the Game-of-Life grid.
// A new generation is captured into the shadow register only at a frame boundary.
module grid_display_scan #(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 16
) (
  input  logic        clka,
  input  logic        rst_n,
  input  logic [63:0] grid,
  input  logic        grid_valid,
  input  logic        enable,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_done,
  output logic [15:0] gen_count,
  output logic [6:0]  alive_count
);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, BLNK} st_e;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [15:0] BLANK_LAST = (BLANK == 0) ? 16'd0 : 16'(BLANK - 1);

  st_e         st_q, st_d;
  logic [2:0]  row_q, row_d;
  logic [15:0] cnt_q, cnt_d;
  logic [63:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic [7:0]  row_sel_q, row_sel_d;
  logic [7:0]  col_data_q, col_data_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] gen_count_q, gen_count_d;
  logic [6:0]  alive_count_q, alive_count_d;
  logic [6:0]  grid_pop;

  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      n = n + {6'b0, v[i]};
    end
    return n;
  endfunction

  assign grid_pop = popcount(grid);

  always_comb begin
    st_d          = st_q;
    row_d         = row_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q | grid_valid;
    gen_count_d   = gen_count_q;
    alive_count_d = alive_count_q;
    frame_done_d  = 1'b0;

    // Dropping enable wins over every state; captured data and pending survive.
    if (!enable) begin
      st_d  = IDLE;
      row_d = '0;
      cnt_d = '0;
    end else begin
      unique case (st_q)
        IDLE: st_d = LOAD;
        LOAD: begin
          if (pending_q || grid_valid) begin
            shadow_d      = grid;
            gen_count_d   = gen_count_q + 16'd1;
            alive_count_d = grid_pop;
            pending_d     = 1'b0;
          end
          row_d = '0;
          cnt_d = '0;
          st_d  = SCAN;
        end
        SCAN: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (BLANK != 0) begin
              st_d = BLNK;
            end else if (row_q == 3'd7) begin
              frame_done_d = 1'b1;
              st_d         = LOAD;
            end else begin
              row_d = row_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        BLNK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d = '0;
            if (row_q == 3'd7) begin
              frame_done_d = 1'b1;
              st_d         = LOAD;
            end else begin
              row_d = row_q + 3'd1;
              st_d  = SCAN;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  // Row drive follows the current state, so it lags the state register by one cycle.
  always_comb begin
    row_sel_d  = '0;
    col_data_d = '0;
    if (enable && (st_q == SCAN)) begin
      row_sel_d  = 8'h01 << row_q;
      col_data_d = shadow_q[{row_q, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      st_q          <= IDLE;
      row_q         <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      row_sel_q     <= '0;
      col_data_q    <= '0;
      frame_done_q  <= 1'b0;
      gen_count_q   <= '0;
      alive_count_q <= '0;
    end else begin
      st_q          <= st_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      row_sel_q     <= row_sel_d;
      col_data_q    <= col_data_d;
      frame_done_q  <= frame_done_d;
      gen_count_q   <= gen_count_d;
      alive_count_q <= alive_count_d;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_data    = col_data_q;
  assign frame_done  = frame_done_q;
  assign gen_count   = gen_count_q;
  assign alive_count = alive_count_q;

endmodule

// File: tb/tb_grid_display_scan.sv
// Scoreboard bench for grid_display_scan: two instances (DWELL=4/BLANK=2 and DWELL=1/BLANK=0)
// share stimulus; a frame-arithmetic model predicts each cycle's outputs.
module tb_grid_display_scan;

  localparam int unsigned D0 = 4;
  localparam int unsigned B0 = 2;
  localparam int unsigned D1 = 1;
  localparam int unsigned B1 = 0;

  logic        clka = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] grid = '0;
  logic        grid_valid = 1'b0;
  logic        enable = 1'b0;

  logic [7:0]  rs0, cd0, rs1, cd1;
  logic        fd0, fd1;
  logic [15:0] gc0, gc1;
  logic [6:0]  ac0, ac1;

  grid_display_scan #(.DWELL(D0), .BLANK(B0)) u_dut (
    .clka(clka), .rst_n(rst_n), .grid(grid), .grid_valid(grid_valid), .enable(enable),
    .row_sel(rs0), .col_data(cd0), .frame_done(fd0), .gen_count(gc0), .alive_count(ac0)
  );

  grid_display_scan #(.DWELL(D1), .BLANK(B1)) u_fast (
    .clka(clka), .rst_n(rst_n), .grid(grid), .grid_valid(grid_valid), .enable(enable),
    .row_sel(rs1), .col_data(cd1), .frame_done(fd1), .gen_count(gc1), .alive_count(ac1)
  );

  always #5 clka = ~clka;

  typedef struct {
    longint      cyc;
    logic [7:0]  rs;
    logic [7:0]  cd;
    logic        fd;
    logic [15:0] gen;
    logic [6:0]  alive;
  } exp_t;

  typedef struct {
    bit          running;
    longint      load_cyc;
    logic [63:0] shadow;
    logic [15:0] gen;
    logic [6:0]  alive;
    bit          pending;
  } mstate_t;

  exp_t        q0[$];
  exp_t        q1[$];
  mstate_t     ms[2];
  longint      cyc = 0;
  longint      reset_cyc = 0;
  longint      fd_last[2] = '{-1, -1};
  longint      fd_prev[2] = '{-1, -1};
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] cur_grid = '0;

  always @(posedge clka) cyc <= cyc + 1;

  function automatic int dwell_of(input int i);
    return (i == 0) ? int'(D0) : int'(D1);
  endfunction

  function automatic int blank_of(input int i);
    return (i == 0) ? int'(B0) : int'(B1);
  endfunction

  // 0 idle, 1 load, 2 scan, 3 blank for cycle k, derived from the frame layout 1 + 8*(D+B).
  function automatic int phase(input int i, input longint k, output int r, output longint o);
    longint per_row;
    longint frame;
    longint w;
    per_row = longint'(dwell_of(i) + blank_of(i));
    frame   = 1 + 8 * per_row;
    r = 0;
    o = -1;
    if (!ms[i].running) return 0;
    o = (k - ms[i].load_cyc) % frame;
    if (o == 0) return 1;
    r = int'((o - 1) / per_row);
    w = (o - 1) % per_row;
    return (w < longint'(dwell_of(i))) ? 2 : 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ms[i].running  = 1'b0;
      ms[i].load_cyc = 0;
      ms[i].shadow   = '0;
      ms[i].gen      = '0;
      ms[i].alive    = '0;
      ms[i].pending  = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input longint k, input bit en, input bit gv,
                            input logic [63:0] g, output exp_t e);
    int          ph;
    int          r;
    longint      o;
    longint      frame;
    logic [63:0] sh;
    logic [7:0]  one;
    one   = 8'h01;
    frame = 1 + 8 * longint'(dwell_of(i) + blank_of(i));
    ph    = phase(i, k, r, o);
    sh    = ms[i].shadow >> (8 * r);
    e.cyc = k + 1;
    e.rs  = (en && ph == 2) ? (one << r) : 8'h00;
    e.cd  = (en && ph == 2) ? sh[7:0] : 8'h00;
    e.fd  = en && ms[i].running && (o == frame - 1);
    if (!en) begin
      ms[i].pending = ms[i].pending | gv;
      ms[i].running = 1'b0;
    end else if (!ms[i].running) begin
      ms[i].pending  = ms[i].pending | gv;
      ms[i].running  = 1'b1;
      ms[i].load_cyc = k + 1;
    end else if (ph == 1 && (ms[i].pending || gv)) begin
      ms[i].shadow  = g;
      ms[i].gen     = ms[i].gen + 16'd1;
      ms[i].alive   = 7'($countones(g));
      ms[i].pending = 1'b0;
    end else begin
      ms[i].pending = ms[i].pending | gv;
    end
    e.gen   = ms[i].gen;
    e.alive = ms[i].alive;
  endtask

  task automatic step(input bit en, input bit gv, input logic [63:0] g);
    exp_t e;
    enable     = en;
    grid_valid = gv;
    grid       = g;
    cur_grid   = g;
    model_step(0, cyc, en, gv, g, e);
    q0.push_back(e);
    model_step(1, cyc, en, gv, g, e);
    q1.push_back(e);
    @(posedge clka);
    #1;
  endtask

  task automatic sb_check(input int i, input logic [39:0] act);
    exp_t       e;
    bit         have;
    logic [39:0] want;
    have = 1'b0;
    if (i == 0) begin
      if (q0.size() > 0 && q0[0].cyc <= cyc) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); have = 1'b1; end
    end
    if (have) begin
      want = {e.rs, e.cd, e.fd, e.gen, e.alive};
      n_cmp++;
      if (e.cyc != cyc || act !== want) begin
        n_bad++;
        $display("FAIL scan%0d cyc=%0d(exp@%0d): got rs=%h cd=%h fd=%b gen=%h alive=%0d, want rs=%h cd=%h fd=%b gen=%h alive=%0d",
                 i, cyc, e.cyc, act[39:32], act[31:24], act[23], act[22:7], act[6:0],
                 e.rs, e.cd, e.fd, e.gen, e.alive);
      end
    end
  endtask

  always @(negedge clka) begin
    if (rst_n) begin
      if (fd0) begin fd_prev[0] = fd_last[0]; fd_last[0] = cyc; end
      if (fd1) begin fd_prev[1] = fd_last[1]; fd_last[1] = cyc; end
      sb_check(0, {rs0, cd0, fd0, gc0, ac0});
      sb_check(1, {rs1, cd1, fd1, gc1, ac1});
    end
  end

  task automatic direct_check(input string name, input logic [39:0] act, input logic [39:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic check_frame(input int i, input longint want);
    n_cmp++;
    if (fd_prev[i] <= reset_cyc || (fd_last[i] - fd_prev[i]) != want) begin
      n_bad++;
      $display("FAIL frame_len%0d: got %0d (pulses at %0d,%0d) want %0d",
               i, fd_last[i] - fd_prev[i], fd_prev[i], fd_last[i], want);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    enable     = 1'b0;
    grid_valid = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
    #1;
    direct_check("reset_outputs0", {rs0, cd0, fd0, gc0, ac0}, '0);
    direct_check("reset_outputs1", {rs1, cd1, fd1, gc1, ac1}, '0);
    @(posedge clka);
    @(posedge clka);
    #1;
    rst_n     = 1'b1;
    reset_cyc = cyc;
  endtask

  // Advance with enable high until the slow instance is at the given phase/row.
  task automatic seek(input int ph, input int row);
    int     r;
    longint o;
    bit     hit;
    hit = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (phase(0, cyc, r, o) == ph && r == row) begin
        hit = 1'b1;
        break;
      end
      step(1'b1, 1'b0, cur_grid);
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL seek: phase %0d row %0d not reached", ph, row);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    bit          en;
    bit          gv;
    logic [63:0] g;
    model_reset();
    #2;
    do_reset();

    step(1'b0, 1'b1, 64'h8040201008040201);
    repeat (2 * 49 + 12) step(1'b1, 1'b0, cur_grid);
    check_frame(0, 49);
    check_frame(1, 9);

    seek(2, 3);
    step(1'b1, 1'b1, '1);
    repeat (60) step(1'b1, 1'b0, cur_grid);

    seek(2, 1);
    step(1'b1, 1'b1, 64'h1);
    repeat (3) step(1'b1, 1'b0, cur_grid);
    step(1'b1, 1'b1, 64'h3);
    repeat (3) step(1'b1, 1'b0, cur_grid);
    step(1'b1, 1'b1, 64'h7);
    repeat (60) step(1'b1, 1'b0, cur_grid);

    seek(1, 0);
    step(1'b1, 1'b1, 64'hFF);
    repeat (60) step(1'b1, 1'b0, cur_grid);

    seek(2, 5);
    repeat (2) step(1'b1, 1'b0, cur_grid);
    repeat (3) step(1'b0, 1'b0, cur_grid);
    repeat (60) step(1'b1, 1'b0, cur_grid);

    repeat (1500) begin
      en = ($urandom_range(0, 39) != 0);
      gv = ($urandom_range(0, 14) == 0);
      g  = {$urandom(), $urandom()};
      step(en, gv, g);
    end

    seek(2, 2);
    do_reset();
    repeat (30) step(1'b1, 1'b0, cur_grid);
    check_frame(1, 9);

    @(negedge clka);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
